hub75_capture: RTL and testbench

HUB75_CAPTURE -- requirements
Module: hub75_capture

---
 rtl/hub75_capture.sv | 133 +++++++++++++
 tb/tb_hub75_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 panel bus snooper: reassembles shifted pixel lines into a row memory
// and reports line/frame timing, output-enable on-time and line-length errors.
module hub75_capture #(
  parameter int length   = 5,
  parameter int scan_bit = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sclk,
  input  logic                       latch,
  input  logic                       oe_b,
  input  logic [2:0]                 rgb1,
  input  logic [2:0]                 rgb2,
  input  logic [scan_bit-1:0]        select,
  input  logic [scan_bit-1:0]        rd_row,
  input  logic [$clog2(length)-1:0]  rd_col,
  output logic [2:0]                 rd_rgb1,
  output logic [2:0]                 rd_rgb2,
  output logic                       line_valid,
  output logic [scan_bit-1:0]        line_row,
  output logic [15:0]                on_count,
  output logic                       frame_done,
  output logic                       err_short,
  output logic                       err_long
);
  localparam int rows  = 2**scan_bit;
  localparam int col_w = $clog2(length);
  localparam int cnt_w = $clog2(length + 2);
  localparam logic [cnt_w-1:0]    cnt_len  = cnt_w'(length);
  localparam logic [cnt_w-1:0]    cnt_max  = cnt_w'(length + 1);
  localparam logic [col_w:0]      col_lim  = (col_w + 1)'(length);
  localparam logic [scan_bit-1:0] last_row = '1;

  logic             sclk_q;
  logic             latch_q;
  logic             armed;
  logic             sclk_rise;
  logic             latch_rise;
  logic [5:0]       shreg      [length];
  logic [5:0]       shreg_next [length];
  logic [5:0]       mem        [rows][length];
  logic [cnt_w-1:0] bit_cnt;
  logic [cnt_w-1:0] bit_cnt_next;
  logic [15:0]      on_cnt;
  logic [15:0]      on_cnt_next;

  // armed stays low for the first cycle after reset so a level that is
  // already high at release only loads the edge registers
  assign sclk_rise  = armed & sclk & ~sclk_q;
  assign latch_rise = armed & latch & ~latch_q;

  // shifted view is what a same-cycle latch must capture
  always_comb begin
    for (int i = 0; i < length - 1; i++) begin
      shreg_next[i] = sclk_rise ? shreg[i+1] : shreg[i];
    end
    shreg_next[length-1] = sclk_rise ? {rgb1, rgb2} : shreg[length-1];
  end

  always_comb begin
    bit_cnt_next = bit_cnt;
    if (sclk_rise && bit_cnt != cnt_max) begin
      bit_cnt_next = bit_cnt + 1'b1;
    end
    on_cnt_next = on_cnt;
    if (!oe_b && on_cnt != 16'hFFFF) begin
      on_cnt_next = on_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
      armed      <= 1'b0;
      bit_cnt    <= '0;
      on_cnt     <= '0;
      on_count   <= '0;
      line_valid <= 1'b0;
      line_row   <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      rd_rgb1    <= '0;
      rd_rgb2    <= '0;
      for (int i = 0; i < length; i++) begin
        shreg[i] <= '0;
      end
      for (int r = 0; r < rows; r++) begin
        for (int i = 0; i < length; i++) begin
          mem[r][i] <= '0;
        end
      end
    end else begin
      sclk_q     <= sclk;
      latch_q    <= latch;
      armed      <= 1'b1;
      line_valid <= latch_rise;
      frame_done <= latch_rise && (select == last_row);
      for (int i = 0; i < length; i++) begin
        shreg[i] <= shreg_next[i];
      end

      // non-blocking read sees the row as it was before any same-cycle write
      if ({1'b0, rd_col} < col_lim) begin
        rd_rgb1 <= mem[rd_row][rd_col][5:3];
        rd_rgb2 <= mem[rd_row][rd_col][2:0];
      end else begin
        rd_rgb1 <= '0;
        rd_rgb2 <= '0;
      end

      if (latch_rise) begin
        for (int i = 0; i < length; i++) begin
          mem[select][i] <= shreg_next[i];
        end
        line_row <= select;
        if (bit_cnt_next < cnt_len) begin
          err_short <= 1'b1;
        end
        if (bit_cnt_next > cnt_len) begin
          err_long <= 1'b1;
        end
        on_count <= on_cnt_next;
        on_cnt   <= '0;
        bit_cnt  <= '0;
      end else begin
        on_cnt   <= on_cnt_next;
        bit_cnt  <= bit_cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_hub75_capture.sv
// Randomized and directed bench for hub75_capture, checked every cycle against
// a pixel-history model of the panel bus.
module tb_hub75_capture;
  localparam int len  = 5;
  localparam int rows = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0, latch = 1'b0, oe_b = 1'b1;
  logic [2:0] rgb1 = '0, rgb2 = '0;
  logic [1:0] select = '0, rd_row = '0;
  logic [2:0] rd_col = '0;
  logic [2:0] rd_rgb1, rd_rgb2;
  logic       line_valid, frame_done, err_short, err_long;
  logic [1:0] line_row;
  logic [15:0] on_count;

  hub75_capture #(.length(len), .scan_bit(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .latch(latch), .oe_b(oe_b),
    .rgb1(rgb1), .rgb2(rgb2), .select(select), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rgb1(rd_rgb1), .rd_rgb2(rd_rgb2), .line_valid(line_valid), .line_row(line_row),
    .on_count(on_count), .frame_done(frame_done), .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: history of the most recent pixels, pixel/on-time counts per line
  logic [5:0] hist[$];
  logic [5:0] m_mem [rows][len];
  int         pix, on;
  bit         armed, p_sclk, p_latch, rs, ls;
  int         idx;
  logic       e_lv, e_fd, e_short, e_long;
  logic [1:0] e_row;
  logic [15:0] e_on;
  logic [2:0] e_rd1, e_rd2;

  task automatic m_clear();
    hist.delete();
    pix = 0; on = 0; armed = 0; p_sclk = 0; p_latch = 0;
    e_lv = 0; e_fd = 0; e_short = 0; e_long = 0; e_row = 0; e_on = 0;
    e_rd1 = 0; e_rd2 = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < len; c++) m_mem[r][c] = '0;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clear();
    end else begin
      if (int'(rd_col) < len) begin
        e_rd1 = m_mem[rd_row][rd_col][5:3];
        e_rd2 = m_mem[rd_row][rd_col][2:0];
      end else begin
        e_rd1 = 0; e_rd2 = 0;
      end
      rs = armed && sclk && !p_sclk;
      ls = armed && latch && !p_latch;
      p_sclk = sclk; p_latch = latch; armed = 1;
      if (rs) begin
        hist.push_back({rgb1, rgb2});
        if (hist.size() > len) void'(hist.pop_front());
        pix++;
      end
      if (!oe_b) on++;
      e_lv = ls;
      e_fd = ls && (int'(select) == rows - 1);
      if (ls) begin
        for (int c = 0; c < len; c++) begin
          idx = hist.size() - len + c;
          m_mem[select][c] = (idx >= 0) ? hist[idx] : 6'd0;
        end
        e_row = select;
        if (pix < len) e_short = 1;
        if (pix > len) e_long = 1;
        e_on = (on > 65535) ? 16'hFFFF : 16'(on);
        on = 0;
        pix = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("line_valid", 32'(line_valid), 32'(e_lv));
      chk("line_row",   32'(line_row),   32'(e_row));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("err_short",  32'(err_short),  32'(e_short));
      chk("err_long",   32'(err_long),   32'(e_long));
      chk("on_count",   32'(on_count),   32'(e_on));
      chk("rd_rgb1",    32'(rd_rgb1),    32'(e_rd1));
      chk("rd_rgb2",    32'(rd_rgb2),    32'(e_rd2));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic shift_px(input int v1, input int v2);
    rgb1 = 3'(v1); rgb2 = 3'(v2); sclk = 1'b1;
    step();
    sclk = 1'b0;
    step();
  endtask

  task automatic shift_n(input int n, input int base);
    for (int k = 0; k < n; k++) shift_px(base + k, 7 - ((base + k) % 8));
  endtask

  // leaves outputs showing the registered result of the latch rise
  task automatic do_latch(input int sel);
    select = 2'(sel); latch = 1'b1;
    step();
    latch = 1'b0; sclk = 1'b0;
  endtask

  task automatic read_chk(input string name, input int row, input int col, input int e1, input int e2);
    rd_row = 2'(row); rd_col = 3'(col);
    step();
    chk({name, "_rgb1"}, 32'(rd_rgb1), 32'(e1));
    chk({name, "_rgb2"}, 32'(rd_rgb2), 32'(e2));
  endtask

  initial begin
    step();
    reset = 1'b0;
    run_cmp = 1'b1;
    step();
    chk("rst_line_valid", 32'(line_valid), 0);
    chk("rst_on_count", 32'(on_count), 0);
    chk("rst_err", 32'({err_short, err_long}), 0);

    // basic line into row 2
    for (int p = 0; p < 5; p++) shift_px(p, 7 - p);
    do_latch(2);
    chk("basic_lv", 32'(line_valid), 1);
    chk("basic_row", 32'(line_row), 2);
    chk("basic_err", 32'({err_short, err_long}), 0);
    step();
    chk("basic_lv_drop", 32'(line_valid), 0);
    for (int c = 0; c < 5; c++) read_chk("basic_rd", 2, c, c, 7 - c);
    read_chk("rd_oob", 2, 6, 0, 0);

    // fifth pixel and latch in the same cycle
    for (int p = 1; p < 5; p++) shift_px(p, p);
    rgb1 = 3'd5; rgb2 = 3'd5; sclk = 1'b1;
    do_latch(1);
    chk("same_cycle_short", 32'(err_short), 0);
    step();
    read_chk("same_cycle_c4", 1, 4, 5, 5);
    read_chk("same_cycle_c0", 1, 0, 1, 1);

    // full frame
    for (int r = 0; r < 4; r++) begin
      shift_n(5, r * 5);
      do_latch(r);
      chk("frame_lv", 32'(line_valid), 1);
      chk("frame_fd", 32'(frame_done), 32'(r == 3));
      step();
    end

    // on-time counting
    oe_b = 1'b0;
    repeat (37) step();
    oe_b = 1'b1;
    shift_n(5, 0);
    do_latch(0);
    chk("on_count_37", 32'(on_count), 37);
    shift_n(5, 1);
    oe_b = 1'b0;
    repeat (70000) step();
    oe_b = 1'b1;
    do_latch(0);
    chk("on_count_sat", 32'(on_count), 32'h0000_FFFF);
    step();

    // short line, then a correct one, then a long one
    shift_n(3, 0);
    do_latch(3);
    chk("short_set", 32'(err_short), 1);
    step();
    shift_n(5, 0);
    do_latch(3);
    chk("short_sticky", 32'(err_short), 1);
    chk("long_clear", 32'(err_long), 0);
    step();
    for (int p = 0; p < 7; p++) shift_px(p, 0);
    do_latch(1);
    chk("long_set", 32'(err_long), 1);
    step();
    for (int c = 0; c < 5; c++) read_chk("long_rd", 1, c, c + 2, 0);

    // reset mid-shift with sclk held high across release
    shift_px(6, 6);
    shift_px(2, 2);
    rgb1 = 3'd5; sclk = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_err", 32'({err_short, err_long}), 0);
    chk("rst_mid_on", 32'(on_count), 0);
    reset = 1'b0;
    step();
    step();
    chk("rst_rel_lv", 32'(line_valid), 0);
    sclk = 1'b0;
    step();
    for (int p = 1; p <= 5; p++) shift_px(p, p);
    do_latch(0);
    chk("rst_rel_err", 32'({err_short, err_long}), 0);
    step();
    read_chk("rst_rel_c0", 0, 0, 1, 1);
    read_chk("rst_rel_other", 2, 0, 0, 0);

    // randomized traffic
    repeat (3000) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      sclk   = 1'($urandom_range(0, 1));
      latch  = ($urandom_range(0, 11) == 0);
      oe_b   = 1'($urandom_range(0, 1));
      rgb1   = 3'($urandom_range(0, 7));
      rgb2   = 3'($urandom_range(0, 7));
      select = 2'($urandom_range(0, 3));
      rd_row = 2'($urandom_range(0, 3));
      rd_col = 3'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
